// File: rtl/key_entry_display.sv
// -----------------------------------------------------------------------------
// key_entry_display
//
// Purpose:
//   Builds a six-digit decimal entry buffer from debounced keypad presses and
//   drives a multiplexed seven-segment display from an external scan index.
//   Keys 0-9 shift a digit in at the right, 0xA clears the buffer, 0xB is
//   backspace and 0xC is enter. Enter locks the buffer until the next clear.
//
// Ports:
//   clk         in   system clock
//   reset       in   asynchronous, active-high reset
//   press_valid in   debounced key-held level
//   key_code    in   key code, stable while press_valid is high
//   sel         in   scan index 0..5 (6 and 7 select no digit)
//   seg         out  segments {dp,g,f,e,d,c,b,a}, active-low, registered
//   dig_en      out  digit enables, one-hot active-low, registered
//   digits      out  entry buffer, digit k at [4k+3:4k], digit 0 is newest
//   count       out  number of valid digits, 0..6
//   locked      out  high once enter has been accepted
//   entry_done  out  one-cycle pulse when enter is accepted
//   overflow    out  sticky flag: digit key pressed with a full buffer
//
// Configuration:
//   LEADING_ZERO_EN  when defined, unused positions show '0' instead of blank.
// -----------------------------------------------------------------------------
module key_entry_display #(
    parameter int NDIG  = 6,
    parameter int KEY_W = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  press_valid,
    input  logic [KEY_W-1:0]      key_code,
    input  logic [2:0]            sel,
    output logic [7:0]            seg,
    output logic [NDIG-1:0]       dig_en,
    output logic [4*NDIG-1:0]     digits,
    output logic [2:0]            count,
    output logic                  locked,
    output logic                  entry_done,
    output logic                  overflow
);

    typedef enum logic {
        ST_ENTRY,
        ST_LOCKED
    } state_t;

    localparam logic [KEY_W-1:0] KEY_NINE  = KEY_W'(9);
    localparam logic [KEY_W-1:0] KEY_CLEAR = KEY_W'(10);
    localparam logic [KEY_W-1:0] KEY_BACK  = KEY_W'(11);
    localparam logic [KEY_W-1:0] KEY_ENTER = KEY_W'(12);
    localparam logic [2:0]       NDIG_SEL  = 3'(NDIG);

    state_t                state_q, state_d;
    logic                  pressValid_q;
    logic [4*NDIG-1:0]     digits_q, digits_d;
    logic [2:0]            count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  entryDone_q, entryDone_d;
    logic [7:0]            seg_q, seg_d;
    logic [NDIG-1:0]       digEn_q, digEn_d;

    logic                  accept;
    logic [3:0]            selDigit;

    // Only the rising edge of the held level counts, so a held key acts once.
    assign accept = press_valid & ~pressValid_q;

    // Seven-segment decode, active-low {dp,g,f,e,d,c,b,a}.
    function automatic logic [7:0] decodeDigit(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = 8'hC0;
            4'd1:    s = 8'hF9;
            4'd2:    s = 8'hA4;
            4'd3:    s = 8'hB0;
            4'd4:    s = 8'h99;
            4'd5:    s = 8'h92;
            4'd6:    s = 8'h82;
            4'd7:    s = 8'hF8;
            4'd8:    s = 8'h80;
            4'd9:    s = 8'h90;
            default: s = 8'hFF;
        endcase
        return s;
    endfunction

    // State and buffer registers; everything clears asynchronously on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_ENTRY;
            pressValid_q <= 1'b0;
            digits_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            entryDone_q  <= 1'b0;
            seg_q        <= 8'hFF;
            digEn_q      <= '1;
        end else begin
            state_q      <= state_d;
            pressValid_q <= press_valid;
            digits_q     <= digits_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            entryDone_q  <= entryDone_d;
            seg_q        <= seg_d;
            digEn_q      <= digEn_d;
        end
    end

    // Key interpretation. While locked, only clear is honoured; clear always
    // returns to entry mode and also drops the sticky overflow flag.
    always_comb begin
        state_d     = state_q;
        digits_d    = digits_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        entryDone_d = 1'b0;
        if (accept) begin
            if (key_code == KEY_CLEAR) begin
                state_d    = ST_ENTRY;
                digits_d   = '0;
                count_d    = '0;
                overflow_d = 1'b0;
            end else if (state_q == ST_ENTRY) begin
                if (key_code <= KEY_NINE) begin
                    if (count_q < NDIG_SEL) begin
                        digits_d = {digits_q[4*NDIG-5:0], key_code[3:0]};
                        count_d  = count_q + 3'd1;
                    end else begin
                        overflow_d = 1'b1;
                    end
                end else if (key_code == KEY_BACK) begin
                    if (count_q != 3'd0) begin
                        digits_d = {4'h0, digits_q[4*NDIG-1:4]};
                        count_d  = count_q - 3'd1;
                    end
                end else if (key_code == KEY_ENTER) begin
                    if (count_q != 3'd0) begin
                        state_d     = ST_LOCKED;
                        entryDone_d = 1'b1;
                    end
                end
            end
        end
    end

    // Pick the buffer nibble addressed by the scan index (out-of-range -> 0).
    always_comb begin
        selDigit = 4'h0;
        for (int k = 0; k < NDIG; k++) begin
            if (sel == 3'(k)) begin
                selDigit = digits_q[4*k +: 4];
            end
        end
    end

    // Display path: the enable for the scanned position goes low even when it
    // is past the valid digits; the decimal point on digit 0 marks a locked entry.
    always_comb begin
        seg_d   = 8'hFF;
        digEn_d = '1;
        if (sel < NDIG_SEL) begin
            digEn_d = ~(NDIG'(1) << sel);
            if (sel < count_q) begin
                seg_d = decodeDigit(selDigit);
            end else begin
`ifdef LEADING_ZERO_EN
                seg_d = 8'hC0;
`else
                seg_d = 8'hFF;
`endif
            end
            if ((sel == 3'd0) && (state_q == ST_LOCKED)) begin
                seg_d[7] = 1'b0;
            end
        end
    end

    assign seg        = seg_q;
    assign dig_en     = digEn_q;
    assign digits     = digits_q;
    assign count      = count_q;
    assign locked     = (state_q == ST_LOCKED);
    assign entry_done = entryDone_q;
    assign overflow   = overflow_q;

endmodule
